// File: rtl/jt89_noise_pkg.sv
// Shared constants and the 9-bit attenuation table for the JT89 noise channel.
// Tone channels use the same table, so both stay at identical levels.
package jt89_noise_pkg;

  localparam logic [15:0] LFSR_SEED = 16'h8000;
  localparam int          TAP_LO    = 0;
  localparam int          TAP_HI    = 3;
  localparam int          DIV_EXP   = 5;

  typedef enum logic [1:0] {
    NF_DIV32  = 2'd0,
    NF_DIV64  = 2'd1,
    NF_DIV128 = 2'd2,
    NF_TONE2  = 2'd3
  } nf_e;

  // 2 dB steps; 15 is silence.
  function automatic logic [8:0] vol_level9(input logic [3:0] vol);
    logic [8:0] lvl;
    case (vol)
      4'd0:    lvl = 9'd511;
      4'd1:    lvl = 9'd406;
      4'd2:    lvl = 9'd322;
      4'd3:    lvl = 9'd256;
      4'd4:    lvl = 9'd203;
      4'd5:    lvl = 9'd161;
      4'd6:    lvl = 9'd128;
      4'd7:    lvl = 9'd101;
      4'd8:    lvl = 9'd81;
      4'd9:    lvl = 9'd64;
      4'd10:   lvl = 9'd51;
      4'd11:   lvl = 9'd40;
      4'd12:   lvl = 9'd32;
      4'd13:   lvl = 9'd25;
      4'd14:   lvl = 9'd20;
      default: lvl = 9'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/jt89_vol.sv
// Combinational attenuation lookup, scaled to the mixer sample width.
// Widths other than 9 shift the table by 2^(bw-9), truncating.
module jt89_vol
  import jt89_noise_pkg::*;
#(
  parameter int bw = 9
) (
  input  logic [3:0]    vol,
  output logic [bw-1:0] level
);

  logic [8:0] base_s;

  assign base_s = vol_level9(vol);

  generate
    if (bw > 9) begin : g_up
      assign level = {base_s, {(bw-9){1'b0}}};
    end else if (bw == 9) begin : g_eq
      assign level = base_s;
    end else begin : g_dn
      assign level = base_s[8 -: bw];
    end
  endgenerate

endmodule

// File: rtl/jt89_noise.sv
// JT89 noise channel: 16-bit LFSR stepped by a clk_en divider or by
// channel-2 rising edges, gated onto an attenuated unsigned output.
module jt89_noise
  import jt89_noise_pkg::*;
#(
  parameter int bw = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic [2:0]    ctrl,
  input  logic          ctrl_wr,
  input  logic [3:0]    vol,
  input  logic          tone2,
  output logic [bw-1:0] noise
);

  logic [6:0]    cnt_q, cnt_d;
  logic          tone2_l_q, tone2_l_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [bw-1:0] noise_q, noise_d;

  logic [bw-1:0] level_s;
  nf_e           nf_s;
  logic [6:0]    div_mask_s;
  logic          div_hit_s;
  logic          tone_hit_s;
  logic          shift_s;
  logic          fb_s;

  jt89_vol #(.bw(bw)) u_vol (
    .vol   (vol),
    .level (level_s)
  );

  // Event detection, LFSR/divider next state and output gating.
  always_comb begin
    nf_s       = nf_e'(ctrl[1:0]);
    // Low 5, 6 or 7 counter bits must all be ones; NF=3 ignores the mask.
    div_mask_s = 7'((32'd1 << (DIV_EXP + int'(ctrl[1:0]))) - 32'd1);
    div_hit_s  = &(cnt_q | ~div_mask_s);
    tone_hit_s = tone2 & ~tone2_l_q;
    if (nf_s == NF_TONE2) begin
      shift_s = clk_en & tone_hit_s;
    end else begin
      shift_s = clk_en & div_hit_s;
    end
    if (ctrl[2]) begin
      fb_s = lfsr_q[TAP_LO] ^ lfsr_q[TAP_HI];
    end else begin
      fb_s = lfsr_q[TAP_LO];
    end

    cnt_d     = cnt_q;
    tone2_l_d = tone2_l_q;
    lfsr_d    = lfsr_q;
    if (clk_en) begin
      cnt_d     = cnt_q + 7'd1;
      tone2_l_d = tone2;
    end else begin
      cnt_d     = cnt_q;
      tone2_l_d = tone2_l_q;
    end
    // A control write reseeds and suppresses any coincident shift.
    if (ctrl_wr) begin
      lfsr_d = LFSR_SEED;
      cnt_d  = 7'd0;
    end else if (shift_s) begin
      lfsr_d = {fb_s, lfsr_q[15:1]};
    end else begin
      lfsr_d = lfsr_q;
    end

    if (lfsr_q[0]) begin
      noise_d = level_s;
    end else begin
      noise_d = {bw{1'b0}};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 7'd0;
      tone2_l_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      noise_q   <= {bw{1'b0}};
    end else begin
      cnt_q     <= cnt_d;
      tone2_l_q <= tone2_l_d;
      lfsr_q    <= lfsr_d;
      noise_q   <= noise_d;
    end
  end

  assign noise = noise_q;

endmodule

// File: tb/tb_jt89_noise.sv
// Directed + randomized bench for jt89_noise against a tick-counting reference model.
module tb_jt89_noise;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic [2:0] ctrl = 3'd0;
  logic       ctrl_wr = 1'b0;
  logic [3:0] vol = 4'd0;
  logic       tone2 = 1'b0;
  logic [8:0] noise;

  int n_asserts = 0;
  int n_fail = 0;

  int vol_tab [16] = '{511, 406, 322, 256, 203, 161, 128, 101, 81, 64, 51, 40, 32, 25, 20, 0};

  // reference model state: ticks since reset/write (mod 128), last sampled tone2
  int m_lfsr  = 32'h8000;
  int m_ticks = 0;
  int m_t2l   = 0;
  int m_noise = 0;

  jt89_noise #(.bw(9)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .ctrl    (ctrl),
    .ctrl_wr (ctrl_wr),
    .vol     (vol),
    .tone2   (tone2),
    .noise   (noise)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit r, input bit ce, input bit cw, input bit [2:0] c,
                      input bit [3:0] v, input bit t2);
    int per, nf, fb, ev;
    rst = r; clk_en = ce; ctrl_wr = cw; ctrl = c; vol = v; tone2 = t2;
    @(posedge clk);
    if (r) begin
      m_lfsr = 32'h8000; m_ticks = 0; m_t2l = 0; m_noise = 0;
    end else begin
      m_noise = (m_lfsr % 2 == 1) ? vol_tab[v] : 0;
      nf = int'(c[1:0]);
      if (nf == 3) begin
        ev = (ce && t2 && m_t2l == 0) ? 1 : 0;
      end else begin
        per = 32 << nf;
        ev = (ce && (m_ticks % per) == per - 1) ? 1 : 0;
      end
      if (ce) begin
        m_ticks = (m_ticks + 1) % 128;
        m_t2l = t2 ? 1 : 0;
      end
      if (cw) begin
        m_lfsr = 32'h8000; m_ticks = 0;
      end else if (ev == 1) begin
        fb = c[2] ? ((m_lfsr ^ (m_lfsr >> 3)) & 1) : (m_lfsr & 1);
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
      end
    end
    #1;
    chk("model_noise", int'(noise), m_noise);
    chk("model_lfsr", int'(dut.lfsr_q), m_lfsr);
  endtask

  initial begin
    int v, tk, rises, changes, prev_lfsr, t2l;
    bit ce, t2;
    bit [2:0] rc;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), 1'($urandom));
    chk("reset_noise", int'(noise), 0);
    chk("reset_lfsr", int'(dut.lfsr_q), 32'h8000);
    chk("reset_cnt", int'(dut.cnt_q), 0);

    // periodic, NF=0, vol=0
    for (int i = 0; i < 1100; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      if (i == 30)  chk("per_before_ev1", int'(dut.lfsr_q), 32'h8000);
      if (i == 31)  chk("per_ev1", int'(dut.lfsr_q), 32'h4000);
      if (i == 478) chk("per_ev14_noise", int'(noise), 0);
      if (i == 479) chk("per_ev15_lfsr", int'(dut.lfsr_q), 32'h0001);
      if (i == 480) chk("per_ev15_noise", int'(noise), 511);
      if (i == 511) chk("per_ev16_lfsr", int'(dut.lfsr_q), 32'h8000);
      if (i == 512) chk("per_ev16_noise", int'(noise), 0);
      if (i == 991) chk("per_repeat_lfsr", int'(dut.lfsr_q), 32'h0001);
    end

    // white, NF=1
    step(1'b0, 1'b0, 1'b1, 3'b101, 4'd3, 1'b0);
    for (int i = 0; i < 1100; i++) begin
      v = int'($urandom_range(0, 15));
      step(1'b0, 1'b1, 1'b0, 3'b101, 4'(v), 1'b0);
      if (i == 62)   chk("wht_before_ev1", int'(dut.lfsr_q), 32'h8000);
      if (i == 63)   chk("wht_ev1", int'(dut.lfsr_q), 32'h4000);
      if (i == 959)  chk("wht_ev15_lfsr", int'(dut.lfsr_q), 32'h2001);
      if (i == 960)  chk("wht_ev15_noise", int'(noise), vol_tab[v]);
      if (i == 1023) chk("wht_ev16_lfsr", int'(dut.lfsr_q), 32'h9000);
    end

    // NF=3: tone2 period 20 clk_en ticks, random clk_en
    step(1'b0, 1'b0, 1'b1, 3'b011, 4'd0, 1'b0);
    tk = 0; rises = 0; changes = 0; t2l = 0;
    prev_lfsr = int'(dut.lfsr_q);
    for (int i = 0; i < 500; i++) begin
      ce = 1'($urandom);
      t2 = ((tk / 10) % 2) == 1;
      if (ce) begin
        if (t2 && t2l == 0) rises++;
        t2l = t2 ? 1 : 0;
        tk++;
      end
      step(1'b0, ce, 1'b0, 3'b011, 4'($urandom), t2);
      if (int'(dut.lfsr_q) != prev_lfsr) changes++;
      prev_lfsr = int'(dut.lfsr_q);
    end
    chk("nf3_shift_count", changes, rises);

    // ctrl_wr colliding with a shift event
    step(1'b0, 1'b0, 1'b1, 3'b000, 4'd0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, (i == 63), 3'b000, 4'd0, 1'b0);
      if (i == 31) chk("col_first_ev", int'(dut.lfsr_q), 32'h4000);
      if (i == 63) chk("col_write_wins", int'(dut.lfsr_q), 32'h8000);
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      if (i == 30) chk("col_no_early", int'(dut.lfsr_q), 32'h8000);
      if (i == 31) chk("col_next_ev", int'(dut.lfsr_q), 32'h4000);
    end

    // volume sweep with lfsr[0]=1 and clk_en low
    step(1'b0, 1'b0, 1'b1, 3'b000, 4'd0, 1'b0);
    for (int i = 0; i < 480; i++) step(1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
    chk("sweep_lfsr", int'(dut.lfsr_q), 32'h0001);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 3'b000, 4'(i), 1'b0);
      chk("sweep_noise", int'(noise), vol_tab[i]);
    end
    chk("sweep_hold_lfsr", int'(dut.lfsr_q), 32'h0001);

    // rst and ctrl_wr together, then first shift at tick 32
    step(1'b1, 1'b1, 1'b1, 3'b111, 4'd0, 1'b1);
    chk("rstwr_noise", int'(noise), 0);
    chk("rstwr_t2l", int'(dut.tone2_l_q), 0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      if (i == 30) chk("rst_no_early", int'(dut.lfsr_q), 32'h8000);
      if (i == 31) chk("rst_first_ev", int'(dut.lfsr_q), 32'h4000);
    end

    // randomized mix, including ctrl changes without writes
    rc = 3'b100; t2 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) rc = 3'($urandom);
      if ($urandom_range(0, 7) == 0) t2 = ~t2;
      step(($urandom_range(0, 299) == 0), 1'($urandom), ($urandom_range(0, 149) == 0),
           rc, 4'($urandom), t2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
